// File: rtl/mul_10_100_1k.sv
// BCD digit weighting: registered x10 / x100 / x1000 products and their sum, 1-cycle latency.
// Optional digit validation is compiled in when MUL_BCD_CHECK_EN is defined.
module mul_10_100_1k #(
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in10,
    input  logic [3:0]       in100,
    input  logic [3:0]       in1k,
    output logic [OUT_W-1:0] out10,
    output logic [OUT_W-1:0] out100,
    output logic [OUT_W-1:0] out1k,
    output logic [OUT_W-1:0] sum_out,
    output logic [2:0]       bcd_err
);

    // Constant multipliers as shift-add networks; OUT_W >= 14 holds every product for inputs 0..15.
    function automatic logic [OUT_W-1:0] times10(input logic [3:0] x);
        logic [OUT_W-1:0] xe;
        xe = OUT_W'(x);
        return (xe << 3) + (xe << 1);
    endfunction

    function automatic logic [OUT_W-1:0] times100(input logic [3:0] x);
        logic [OUT_W-1:0] xe;
        xe = OUT_W'(x);
        return (xe << 6) + (xe << 5) + (xe << 2);
    endfunction

    // 1024x always exceeds 24x, so the subtractions never wrap.
    function automatic logic [OUT_W-1:0] times1000(input logic [3:0] x);
        logic [OUT_W-1:0] xe;
        xe = OUT_W'(x);
        return (xe << 10) - (xe << 4) - (xe << 3);
    endfunction

    // Modulo-2^OUT_W addition; only reachable with non-BCD digits and a narrow OUT_W.
    function automatic logic [OUT_W-1:0] sum_trunc(
        input logic [OUT_W-1:0] a,
        input logic [OUT_W-1:0] b,
        input logic [OUT_W-1:0] c
    );
        return a + b + c;
    endfunction

    logic [OUT_W-1:0] out10_d,   out10_q;
    logic [OUT_W-1:0] out100_d,  out100_q;
    logic [OUT_W-1:0] out1k_d,   out1k_q;
    logic [OUT_W-1:0] sum_out_d, sum_out_q;

`ifdef MUL_BCD_CHECK_EN
    logic [2:0] bcd_err_d, bcd_err_q;

    always_comb begin
        bcd_err_d = {in1k > 4'd9, in100 > 4'd9, in10 > 4'd9};
        out10_d   = bcd_err_d[0] ? '0 : times10(in10);
        out100_d  = bcd_err_d[1] ? '0 : times100(in100);
        out1k_d   = bcd_err_d[2] ? '0 : times1000(in1k);
        sum_out_d = sum_trunc(out10_d, out100_d, out1k_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_err_q <= 3'b000;
        end else begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bcd_err = bcd_err_q;
`else
    always_comb begin
        out10_d   = times10(in10);
        out100_d  = times100(in100);
        out1k_d   = times1000(in1k);
        sum_out_d = sum_trunc(out10_d, out100_d, out1k_d);
    end

    assign bcd_err = 3'b000;
`endif

    // Sum is formed from the same combinational products, so it shares the products' edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out10_q   <= '0;
            out100_q  <= '0;
            out1k_q   <= '0;
            sum_out_q <= '0;
        end else begin
            out10_q   <= out10_d;
            out100_q  <= out100_d;
            out1k_q   <= out1k_d;
            sum_out_q <= sum_out_d;
        end
    end

    assign out10   = out10_q;
    assign out100  = out100_q;
    assign out1k   = out1k_q;
    assign sum_out = sum_out_q;

endmodule

// File: tb/tb_mul_10_100_1k.sv
// Testbench for mul_10_100_1k: directed scenarios plus randomized digits against an arithmetic model.
// Honours MUL_BCD_CHECK_EN the same way the design does.
module tb_mul_10_100_1k;

    localparam int OUT_W = 14;

    logic             clk;
    logic             rst;
    logic [3:0]       in10, in100, in1k;
    logic [OUT_W-1:0] out10, out100, out1k, sum_out;
    logic [2:0]       bcd_err;

    int checks;
    int failures;

    mul_10_100_1k #(.OUT_W(OUT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in10    (in10),
        .in100   (in100),
        .in1k    (in1k),
        .out10   (out10),
        .out100  (out100),
        .out1k   (out1k),
        .sum_out (sum_out),
        .bcd_err (bcd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal weights applied with ordinary integer arithmetic.
    function automatic void model(input int a, input int b, input int c,
                                  output int e10, output int e100, output int e1k,
                                  output int esum, output int eerr);
        bit bad_a, bad_b, bad_c;
`ifdef MUL_BCD_CHECK_EN
        bad_a = (a > 9);
        bad_b = (b > 9);
        bad_c = (c > 9);
`else
        bad_a = 0;
        bad_b = 0;
        bad_c = 0;
`endif
        e10  = bad_a ? 0 : a * 10;
        e100 = bad_b ? 0 : b * 100;
        e1k  = bad_c ? 0 : c * 1000;
        esum = (e10 + e100 + e1k) % (1 << OUT_W);
        eerr = (bad_c ? 4 : 0) + (bad_b ? 2 : 0) + (bad_a ? 1 : 0);
    endfunction

    // Inputs change at negedge; results are sampled at the following negedge.
    task automatic drive_and_step(input int a, input int b, input int c);
        in10  = 4'(a);
        in100 = 4'(b);
        in1k  = 4'(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in10 = 4'd9; in100 = 4'd9; in1k = 4'd9;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out10 !== '0 || out100 !== '0 || out1k !== '0 || sum_out !== '0 || bcd_err !== 3'b000) begin
            failures++;
            $display("FAIL reset_async: got %0d/%0d/%0d sum=%0d err=%b, want all 0",
                     out10, out100, out1k, sum_out, bcd_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out10 !== '0 || out100 !== '0 || out1k !== '0 || sum_out !== '0) begin
            failures++;
            $display("FAIL reset_held: got %0d/%0d/%0d sum=%0d, want all 0",
                     out10, out100, out1k, sum_out);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out10 !== 14'd90 || out100 !== 14'd900 || out1k !== 14'd9000 || sum_out !== 14'd9990) begin
            failures++;
            $display("FAIL reset_release: got %0d/%0d/%0d sum=%0d, want 90/900/9000 sum=9990",
                     out10, out100, out1k, sum_out);
        end
    endtask

    task automatic test_sweep;
        int e10, e100, e1k, esum, eerr;
        for (int ch = 0; ch < 3; ch++) begin
            for (int d = 1; d <= 9; d++) begin
                int a, b, c;
                a = (ch == 0) ? d : 0;
                b = (ch == 1) ? d : 0;
                c = (ch == 2) ? d : 0;
                drive_and_step(a, b, c);
                model(a, b, c, e10, e100, e1k, esum, eerr);
                checks++;
                if (out10 !== OUT_W'(e10) || out100 !== OUT_W'(e100) || out1k !== OUT_W'(e1k)
                    || sum_out !== OUT_W'(esum)) begin
                    failures++;
                    $display("FAIL sweep ch%0d d=%0d: got %0d/%0d/%0d sum=%0d, want %0d/%0d/%0d sum=%0d",
                             ch, d, out10, out100, out1k, sum_out, e10, e100, e1k, esum);
                end
            end
        end
    endtask

    task automatic test_mixed;
        drive_and_step(3, 7, 5);
        checks++;
        if (out10 !== 14'd30 || out100 !== 14'd700 || out1k !== 14'd5000 || sum_out !== 14'd5730) begin
            failures++;
            $display("FAIL mixed_375: got %0d/%0d/%0d sum=%0d, want 30/700/5000 sum=5730",
                     out10, out100, out1k, sum_out);
        end
    endtask

    task automatic test_hold_between_edges;
        drive_and_step(3, 7, 5);
        in10 = 4'd9; in100 = 4'd1; in1k = 4'd2;
        #2;
        checks++;
        if (out10 !== 14'd30 || out100 !== 14'd700 || out1k !== 14'd5000 || sum_out !== 14'd5730) begin
            failures++;
            $display("FAIL hold: got %0d/%0d/%0d sum=%0d, want 30/700/5000 sum=5730",
                     out10, out100, out1k, sum_out);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out10 !== 14'd90 || out100 !== 14'd100 || out1k !== 14'd2000 || sum_out !== 14'd2190) begin
            failures++;
            $display("FAIL hold_update: got %0d/%0d/%0d sum=%0d, want 90/100/2000 sum=2190",
                     out10, out100, out1k, sum_out);
        end
    endtask

    task automatic test_invalid_digits;
        int e10, e100, e1k, esum, eerr;
        drive_and_step(0, 0, 12);
        model(0, 0, 12, e10, e100, e1k, esum, eerr);
        checks++;
        if (out1k !== OUT_W'(e1k) || sum_out !== OUT_W'(esum) || bcd_err !== 3'(eerr)) begin
            failures++;
            $display("FAIL in1k_12: got out1k=%0d sum=%0d err=%b, want out1k=%0d sum=%0d err=%0d",
                     out1k, sum_out, bcd_err, e1k, esum, eerr);
        end
        drive_and_step(15, 15, 15);
        model(15, 15, 15, e10, e100, e1k, esum, eerr);
        checks++;
        if (out10 !== OUT_W'(e10) || out100 !== OUT_W'(e100) || out1k !== OUT_W'(e1k)
            || sum_out !== OUT_W'(esum) || bcd_err !== 3'(eerr)) begin
            failures++;
            $display("FAIL all_15: got %0d/%0d/%0d sum=%0d err=%b, want %0d/%0d/%0d sum=%0d err=%0d",
                     out10, out100, out1k, sum_out, bcd_err, e10, e100, e1k, esum, eerr);
        end
        drive_and_step(10, 4, 11);
        model(10, 4, 11, e10, e100, e1k, esum, eerr);
        checks++;
        if (out10 !== OUT_W'(e10) || out100 !== OUT_W'(e100) || out1k !== OUT_W'(e1k)
            || sum_out !== OUT_W'(esum) || bcd_err !== 3'(eerr)) begin
            failures++;
            $display("FAIL mix_invalid: got %0d/%0d/%0d sum=%0d err=%b, want %0d/%0d/%0d sum=%0d err=%0d",
                     out10, out100, out1k, sum_out, bcd_err, e10, e100, e1k, esum, eerr);
        end
    endtask

    task automatic test_random;
        int e10, e100, e1k, esum, eerr;
        for (int i = 0; i < 300; i++) begin
            int a, b, c;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 15));
            drive_and_step(a, b, c);
            model(a, b, c, e10, e100, e1k, esum, eerr);
            checks++;
            if (out10 !== OUT_W'(e10) || out100 !== OUT_W'(e100) || out1k !== OUT_W'(e1k)
                || sum_out !== OUT_W'(esum) || bcd_err !== 3'(eerr)) begin
                failures++;
                $display("FAIL random %0d in=%0d/%0d/%0d: got %0d/%0d/%0d sum=%0d err=%b, want %0d/%0d/%0d sum=%0d err=%0d",
                         i, a, b, c, out10, out100, out1k, sum_out, bcd_err, e10, e100, e1k, esum, eerr);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive_and_step(8, 6, 4);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out10 !== '0 || out100 !== '0 || out1k !== '0 || sum_out !== '0 || bcd_err !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_async: got %0d/%0d/%0d sum=%0d err=%b, want all 0",
                     out10, out100, out1k, sum_out, bcd_err);
        end
        in10 = 4'd2; in100 = 4'd3; in1k = 4'd9;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out10 !== '0 || out100 !== '0 || out1k !== '0 || sum_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_held: got %0d/%0d/%0d sum=%0d, want all 0",
                     out10, out100, out1k, sum_out);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out10 !== 14'd20 || out100 !== 14'd300 || out1k !== 14'd9000 || sum_out !== 14'd9320) begin
            failures++;
            $display("FAIL reset_mid_reload: got %0d/%0d/%0d sum=%0d, want 20/300/9000 sum=9320",
                     out10, out100, out1k, sum_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sweep();
        test_mixed();
        test_hold_between_edges();
        test_invalid_digits();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_10_100_1k.md
MUL_10_100_1K -- requirements
Module: mul_10_100_1k

Interface
REQ-001 The block SHALL have parameter OUT_W, default 14, giving the product and sum output width; values below 14 are unsupported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in10, input, 4 bits: BCD tens digit.
REQ-005 The block SHALL have port in100, input, 4 bits: BCD hundreds digit.
REQ-006 The block SHALL have port in1k, input, 4 bits: BCD thousands digit.
REQ-007 The block SHALL have port out10, output, OUT_W bits: registered in10 x 10.
REQ-008 The block SHALL have port out100, output, OUT_W bits: registered in100 x 100.
REQ-009 The block SHALL have port out1k, output, OUT_W bits: registered in1k x 1000.
REQ-010 The block SHALL have port sum_out, output, OUT_W bits: registered out10 + out100 + out1k of the same sample.
REQ-011 The block SHALL have port bcd_err, output, 3 bits: per-channel invalid-digit flag, where bit0 = in10, bit1 = in100 and bit2 = in1k.

Function
REQ-012 Each channel SHALL sample its input on every rising clk edge and present the unsigned product on its output after that same edge, giving 1-cycle latency with no enable.
REQ-013 The products SHALL be exact unsigned binary, zero-extended to OUT_W; the maximum for input 15 is 150 / 1500 / 15000, which fits in 14 bits without overflow.
REQ-014 The multiplications SHALL be implemented as constant shift-add only, with no generic multiplier:
  - x10 = (x<<3)+(x<<1)
  - x100 = (x<<6)+(x<<5)+(x<<2)
  - x1000 = (x<<10)-(x<<4)-(x<<3)
REQ-015 The three channels SHALL be fully independent; changing one input SHALL NOT affect the other outputs.
REQ-016 sum_out SHALL be computed from the same-edge input samples and update on the same edge as the products, so it also has 1-cycle latency.
REQ-017 sum_out SHALL be truncated to OUT_W bits if it exceeds 2^OUT_W-1; the maximum with valid digits is 9990, which never truncates.
REQ-018 An input change between clock edges SHALL NOT alter the outputs until the next rising edge.

Reset
REQ-019 While rst=1, all outputs SHALL be 0 immediately (asynchronously), regardless of clk.
REQ-020 After rst deasserts, the first rising edge SHALL load products of the current inputs.
REQ-021 Asserting rst mid-operation SHALL discard any pending value; no output SHALL retain a pre-reset value after reset.

Configuration
REQ-022 The macro MUL_BCD_CHECK_EN SHALL enable BCD validation when defined.
REQ-023 With MUL_BCD_CHECK_EN defined, any channel input in 10..15 SHALL force that channel's registered product to 0, exclude it from sum_out, and set its bcd_err bit for that cycle.
REQ-024 With MUL_BCD_CHECK_EN undefined, inputs 10..15 SHALL yield the full binary product, and bcd_err SHALL be tied to 3'b000.

Verification
REQ-025 Scenario: rst=1 with inputs 9/9/9 -> all outputs and bcd_err are 0 with no clock edge needed.
REQ-026 Scenario: sweep in10 = 1..9 with the other inputs at 0 -> one edge later out10 = 10..90 and sum_out = out10.
REQ-027 Scenario: sweep in100 = 1..9 and then in1k = 1..9 -> out100 = 100..900 and out1k = 1000..9000, each one cycle after its input.
REQ-028 Scenario: in10=3, in100=7, in1k=5 -> next edge gives out10=30, out100=700, out1k=5000, sum_out=5730.
REQ-029 Scenario: in1k=12 -> without the macro, out1k=12000 and bcd_err=0; with the macro, out1k=0 and bcd_err=3'b100.
REQ-030 Scenario: assert rst between edges while outputs are nonzero -> outputs clear at once; deassert -> the next edge reloads the correct products.
